jpeg_top_enc: RTL and testbench

- Output stage of the JPEG encoder.
- Accepts variable-length entropy codes (0-16 bits), one per enabled cycle, and packs them MSB-first into 32-bit bitstream words.
- On end-of-file it flushes the final partial word, reporting how many of its bits are valid.
- Sits between the Huffman coder and the byte-stuffing/output FIFO. 0xFF/0x00 byte stuffing is not done here.

---
 rtl/jpeg_pkg.sv | 54 +++++
 rtl/jpeg_top_enc.sv | 116 +++++++++++
 tb/tb_jpeg_top_enc.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and helpers for the JPEG bitstream packer: input field
// positions, word geometry, code decoding and the merge/pad arithmetic.
package jpeg_pkg;

  localparam int WORD_W   = 32;
  localparam int MAX_CODE = 16;
  localparam int LEN_HI   = 20;
  localparam int LEN_LO   = 16;
  localparam int LEN_W    = LEN_HI - LEN_LO + 1;   // 5-bit length field
  localparam int CNT_W    = 5;                     // fill count 0..31
  localparam int ACC_W    = 2 * WORD_W;            // merge window

  // Padding used for the unused tail of the flushed partial word.
  localparam logic [WORD_W-1:0] PAD_WORD = '1;

  // One decoded entropy code: clamped length and masked, right-justified bits.
  typedef struct packed {
    logic [LEN_W-1:0]    len;
    logic [MAX_CODE-1:0] bits;
  } code_t;

  // Clamp the length to MAX_CODE and zero every code bit above that length,
  // so the merge below can OR codes in without clearing anything first.
  function automatic code_t decode_code(input logic [LEN_W-1:0]    raw_len,
                                        input logic [MAX_CODE-1:0] raw_bits);
    code_t             c;
    logic [MAX_CODE:0] mask;
    c.len  = (raw_len > LEN_W'(MAX_CODE)) ? LEN_W'(MAX_CODE) : raw_len;
    mask   = ((MAX_CODE+1)'(1) << c.len) - (MAX_CODE+1)'(1);
    c.bits = raw_bits & mask[MAX_CODE-1:0];
    return c;
  endfunction

  // Place the new code directly after the 'fill' valid residue bits in a
  // 64-bit window. The upper half is the (possibly full) output word, the
  // lower half holds overflow bits already left-justified for the next word.
  // Callers only use the result when c.len > 0, which keeps the shift <= 63.
  function automatic logic [ACC_W-1:0] merge_code(input logic [WORD_W-1:0] residue,
                                                  input logic [CNT_W-1:0]  fill,
                                                  input code_t             c);
    logic [ACC_W-1:0] ext;
    logic [6:0]       sh;
    ext = {{(ACC_W-MAX_CODE){1'b0}}, c.bits};
    sh  = 7'd64 - {2'b00, fill} - {2'b00, c.len};
    return {residue, {WORD_W{1'b0}}} | (ext << sh);
  endfunction

  // Final partial word: valid residue bits on top, pad bits below them.
  function automatic logic [WORD_W-1:0] pad_partial(input logic [WORD_W-1:0] residue,
                                                    input logic [CNT_W-1:0]  fill);
    return residue | (PAD_WORD >> fill);
  endfunction

endpackage

// File: rtl/jpeg_top_enc.sv
// JPEG encoder output stage: packs 0..16-bit entropy codes MSB-first into
// 32-bit words and flushes a 1s-padded partial word at end of file.
module jpeg_top_enc
  import jpeg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        end_of_file_signal,
  input  logic        enable,
  input  logic [23:0] data_in,
  output logic [31:0] JPEG_bitstream,
  output logic        data_ready,
  output logic [4:0]  end_of_file_bitstream_count,
  output logic        eof_data_partial_ready
);

  // Residue is kept left-justified; bits below the fill count are always 0.
  logic [WORD_W-1:0] r_residue;
  logic [CNT_W-1:0]  r_fill;
  logic              r_flush_pending;
  logic [WORD_W-1:0] r_bitstream;
  logic              r_data_ready;
  logic              r_eof_ready;
  logic [CNT_W-1:0]  r_eof_count;

  code_t             w_code;
  logic              w_take;
  logic [CNT_W:0]    w_sum;
  logic [ACC_W-1:0]  w_merged;
  logic              w_full;
  logic [WORD_W-1:0] w_next_residue;
  logic [CNT_W-1:0]  w_next_fill;
  logic              w_unused_hi;

  // data_in[23:21] carries nothing for this stage.
  assign w_unused_hi = ^data_in[23:21];

  // Merge the incoming code with the residue and derive the post-code state.
  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path can
    // leave it unassigned and infer a latch.
    w_next_residue = r_residue;
    w_next_fill    = r_fill;
    w_code   = decode_code(data_in[LEN_HI:LEN_LO], data_in[MAX_CODE-1:0]);
    w_take   = enable && (w_code.len != '0);
    w_sum    = {1'b0, r_fill} + {1'b0, w_code.len};
    w_merged = merge_code(r_residue, r_fill, w_code);
    w_full   = w_take && (w_sum >= (CNT_W+1)'(WORD_W));
    if (w_full) begin
      // Lower half of the window is the overflow; w_sum wraps to F + L - 32.
      w_next_residue = w_merged[WORD_W-1:0];
      w_next_fill    = w_sum[CNT_W-1:0];
    end else if (w_take) begin
      w_next_residue = w_merged[ACC_W-1:WORD_W];
      w_next_fill    = w_sum[CNT_W-1:0];
    end
  end

  // Packing state, flush sequencing and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_residue       <= '0;
      r_fill          <= '0;
      r_flush_pending <= 1'b0;
      r_bitstream     <= '0;
      r_data_ready    <= 1'b0;
      r_eof_ready     <= 1'b0;
      r_eof_count     <= '0;
    end else begin
      r_data_ready <= 1'b0;
      r_eof_ready  <= 1'b0;
      r_eof_count  <= '0;
      if (r_flush_pending) begin
        // Second half of an overflowing EOF; this cycle's inputs are dropped.
        r_bitstream     <= pad_partial(r_residue, r_fill);
        r_eof_ready     <= 1'b1;
        r_eof_count     <= r_fill;
        r_residue       <= '0;
        r_fill          <= '0;
        r_flush_pending <= 1'b0;
      end else begin
        if (w_full) begin
          r_bitstream  <= w_merged[ACC_W-1:WORD_W];
          r_data_ready <= 1'b1;
        end
        if (!end_of_file_signal) begin
          r_residue <= w_next_residue;
          r_fill    <= w_next_fill;
        end else if (w_next_fill == '0) begin
          // Nothing left to flush; start the next frame empty.
          r_residue <= '0;
          r_fill    <= '0;
        end else if (w_full) begin
          // Full word goes out now; the partial follows next cycle.
          r_residue       <= w_next_residue;
          r_fill          <= w_next_fill;
          r_flush_pending <= 1'b1;
        end else begin
          r_bitstream <= pad_partial(w_next_residue, w_next_fill);
          r_eof_ready <= 1'b1;
          r_eof_count <= w_next_fill;
          r_residue   <= '0;
          r_fill      <= '0;
        end
      end
    end
  end

  assign JPEG_bitstream              = r_bitstream;
  assign data_ready                  = r_data_ready;
  assign end_of_file_bitstream_count = r_eof_count;
  assign eof_data_partial_ready      = r_eof_ready;

endmodule

// File: tb/tb_jpeg_top_enc.sv
// Self-checking bench for jpeg_top_enc: a bit-queue reference model predicts
// every cycle's outputs; directed cases pin the model with literal values.
module tb_jpeg_top_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        end_of_file_signal;
  logic        enable;
  logic [23:0] data_in;
  logic [31:0] JPEG_bitstream;
  logic        data_ready;
  logic [4:0]  end_of_file_bitstream_count;
  logic        eof_data_partial_ready;

  jpeg_top_enc dut (
    .clk                         (clk),
    .rst                         (rst),
    .end_of_file_signal          (end_of_file_signal),
    .enable                      (enable),
    .data_in                     (data_in),
    .JPEG_bitstream              (JPEG_bitstream),
    .data_ready                  (data_ready),
    .end_of_file_bitstream_count (end_of_file_bitstream_count),
    .eof_data_partial_ready      (eof_data_partial_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending bits as a plain queue, first bit at the front.
  bit          m_bits[$];
  bit          m_pend;
  logic [31:0] exp_word;
  logic        exp_dr;
  logic        exp_pe;
  logic [4:0]  exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    logic [31:0] w;
    w = '1;
    for (int i = 0; i < m_bits.size(); i++) w[31-i] = m_bits[i];
    exp_word = w;
    exp_pe   = 1'b1;
    exp_cnt  = 5'(m_bits.size());
    m_bits.delete();
  endtask

  // Outputs expected right after the edge that samples these inputs.
  task automatic model_cycle(input logic r, input logic en, input logic eof,
                             input logic [23:0] din);
    int          len;
    bit          full;
    logic [31:0] w;
    exp_dr = 1'b0; exp_pe = 1'b0; exp_cnt = '0; full = 1'b0;
    if (r) begin
      m_bits.delete(); m_pend = 1'b0; exp_word = '0;
      return;
    end
    if (m_pend) begin
      m_pend = 1'b0;
      model_flush();
      return;
    end
    if (en) begin
      len = int'(din[20:16]);
      if (len > 16) len = 16;
      for (int i = len - 1; i >= 0; i--) m_bits.push_back(din[i]);
    end
    if (m_bits.size() >= 32) begin
      for (int i = 0; i < 32; i++) w[31-i] = m_bits.pop_front();
      exp_word = w; exp_dr = 1'b1; full = 1'b1;
    end
    if (eof && m_bits.size() > 0) begin
      if (full) m_pend = 1'b1;
      else      model_flush();
    end
  endtask

  // Drive one cycle, advance past the edge, compare all outputs to the model.
  task automatic step(input logic r, input logic en, input logic eof, input logic [23:0] din);
    rst = r; enable = en; end_of_file_signal = eof; data_in = din;
    model_cycle(r, en, eof, din);
    @(posedge clk);
    #1;
    check("data_ready",   32'(data_ready),                  32'(exp_dr));
    check("partial_rdy",  32'(eof_data_partial_ready),      32'(exp_pe));
    check("eof_count",    32'(end_of_file_bitstream_count), 32'(exp_cnt));
    check("bitstream",    JPEG_bitstream,                   exp_word);
  endtask

  function automatic logic [23:0] code(input int len, input int bits);
    return {3'b000, 5'(len), 16'(bits)};
  endfunction

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; end_of_file_signal = 1'b0; data_in = '0;
    m_pend = 1'b0; exp_word = '0;

    // Reset held 3 cycles while enable toggles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 1'b0, code(16, 16'hFFFF));
    check("lit_reset_word", JPEG_bitstream, 32'h0);
    idle(); idle();

    // Eight 4-bit 0xA codes form one word on the 8th.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, code(4, 4'hA));
      if (i < 7) check("lit_a_early", 32'(data_ready), 32'h0);
    end
    check("lit_a_ready", 32'(data_ready), 32'h1);
    check("lit_a_word", JPEG_bitstream, 32'hAAAAAAAA);
    idle();
    check("lit_a_hold", JPEG_bitstream, 32'hAAAAAAAA);

    // Straddle: 30 zero bits, then 5 ones, then EOF alone.
    step(1'b0, 1'b1, 1'b0, code(15, 0));
    step(1'b0, 1'b1, 1'b0, code(15, 0));
    step(1'b0, 1'b1, 1'b0, code(5, 5'h1F));
    check("lit_str_word", JPEG_bitstream, 32'h00000003);
    step(1'b0, 1'b0, 1'b1, 24'h0);
    check("lit_str_part", JPEG_bitstream, 32'hFFFFFFFF);
    check("lit_str_cnt", 32'(end_of_file_bitstream_count), 32'd3);
    idle();

    // EOF together with a 12-bit code from empty.
    step(1'b0, 1'b1, 1'b1, code(12, 12'hABC));
    check("lit_res_word", JPEG_bitstream, 32'hABCFFFFF);
    check("lit_res_cnt", 32'(end_of_file_bitstream_count), 32'd12);
    check("lit_res_dr", 32'(data_ready), 32'h0);
    idle();

    // Aligned EOF: exactly one word, no partial.
    step(1'b0, 1'b1, 1'b0, code(16, 16'h1234));
    step(1'b0, 1'b1, 1'b1, code(16, 16'h5678));
    check("lit_al_word", JPEG_bitstream, 32'h12345678);
    idle();
    check("lit_al_nopart", 32'(eof_data_partial_ready), 32'h0);

    // Overflowing EOF: word, then partial one cycle later.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, code(4, 0));
    step(1'b0, 1'b1, 1'b1, code(8, 8'hFF));
    check("lit_ov_word", JPEG_bitstream, 32'h0000000F);
    idle();
    check("lit_ov_part", JPEG_bitstream, 32'hFFFFFFFF);
    check("lit_ov_cnt", 32'(end_of_file_bitstream_count), 32'd4);
    idle();

    // Reset mid-frame after 10 bits; next word must be clean.
    step(1'b0, 1'b1, 1'b0, code(10, 10'h3FF));
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b1, 1'b0, code(16, 16'h1234));
    step(1'b0, 1'b1, 1'b0, code(16, 16'h5678));
    check("lit_rst_word", JPEG_bitstream, 32'h12345678);
    idle();

    // Randomised traffic: lengths 0..31, junk upper bits, random EOF/reset.
    for (int i = 0; i < 3000; i++) begin
      logic [23:0] d;
      logic        en, eof, r;
      d   = 24'($urandom);
      if ($urandom_range(0, 3) == 0) d[20:16] = 5'($urandom_range(0, 2));
      en  = ($urandom_range(0, 3) != 0);
      eof = ($urandom_range(0, 11) == 0);
      r   = ($urandom_range(0, 299) == 0);
      step(r, en, eof, d);
    end

    // Final EOF to drain and a couple of idle cycles.
    step(1'b0, 1'b0, 1'b1, 24'h0);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
